tdr_scan_chain_crc: RTL and testbench

Parametrised IEEE 1838 test data register (TDR) scan chain with CRC-protected update. Shifted-in payload is checked against a trailing CRC before it reaches the update register. An optional keystream descrambler sits on TDI. It is the next-generation serial TDR inside the 3D-IC die wrapper, driven by the TAP/FSM shift, capture and update strobes.

---
 rtl/tdr_scan_pkg.sv | 28 ++
 rtl/tdr_keystream_lfsr.sv | 36 +++
 rtl/tdr_scan_chain_crc.sv | 152 +++++++++++++++
 tb/tb_tdr_scan_chain_crc.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tdr_scan_pkg.sv
// rtl/tdr_scan_pkg.sv - shared constants, strobe decode type and CRC step for the TDR scan chain
package tdr_scan_pkg;

    localparam int unsigned     CRC_MAX_W     = 32;
    localparam logic [7:0]      DEF_CRC_POLY  = 8'h07;
    localparam logic [15:0]     DEF_LFSR_SEED = 16'hACE1;
    // Fibonacci taps x^16+x^14+x^13+x^11+1 seen from a right-shifting register
    localparam logic [15:0]     LFSR_TAP_MASK = 16'h002D;

    typedef enum logic [1:0] {
        ACT_IDLE,
        ACT_CAPTURE,
        ACT_SHIFT,
        ACT_UPDATE
    } scan_act_e;

    // One MSB-first CRC step; crc and poly are left-aligned in CRC_MAX_W bits
    function automatic logic [CRC_MAX_W-1:0] crc_step(
        input logic [CRC_MAX_W-1:0] crc,
        input logic                 din_bit,
        input logic [CRC_MAX_W-1:0] poly
    );
        logic fb;
        fb = crc[CRC_MAX_W-1] ^ din_bit;
        return {crc[CRC_MAX_W-2:0], 1'b0} ^ (fb ? poly : '0);
    endfunction

endpackage

// File: rtl/tdr_keystream_lfsr.sv
// rtl/tdr_keystream_lfsr.sv - 16-bit Fibonacci keystream LFSR for the TDI descrambler
module tdr_keystream_lfsr
    import tdr_scan_pkg::*;
#(
    parameter logic [15:0] SEED = DEF_LFSR_SEED
) (
    input  logic tck,
    input  logic reset_n,
    input  logic reseed,
    input  logic advance,
    output logic ks
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (reseed) begin
            lfsr_d = SEED;
        end else if (advance) begin
            lfsr_d = {^(lfsr_q & LFSR_TAP_MASK), lfsr_q[15:1]};
        end
    end

    always_ff @(posedge tck or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign ks = lfsr_q[0];

endmodule

// File: rtl/tdr_scan_chain_crc.sv
// rtl/tdr_scan_chain_crc.sv - IEEE 1838 serial TDR with CRC-checked update
// Optional TDI keystream descrambler enabled by macro SCAN_DESCRAMBLE_EN.
module tdr_scan_chain_crc
    import tdr_scan_pkg::*;
#(
    parameter int unsigned       WIDTH     = 128,
    parameter int unsigned       CRC_W     = 8,
    parameter logic [CRC_W-1:0]  CRC_POLY  = CRC_W'(DEF_CRC_POLY),
    parameter logic [15:0]       LFSR_SEED = DEF_LFSR_SEED
) (
    input  logic             tck,
    input  logic             reset_n,
    input  logic             TDI,
    input  logic             shift_en,
    input  logic             capture_en,
    input  logic             update_en,
    input  logic [WIDTH-1:0] capture_data,
    output logic [WIDTH-1:0] update_data,
    output logic             update_valid,
    output logic             crc_ok,
    output logic             crc_err,
    output logic             TDO
);

    localparam int unsigned          FRAME_W     = WIDTH + CRC_W;
    localparam int unsigned          CNT_W       = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0]     CNT_FULL    = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0]     CNT_PAYLOAD = CNT_W'(WIDTH);
    localparam logic [CRC_MAX_W-1:0] POLY_AL     = CRC_MAX_W'(CRC_POLY) << (CRC_MAX_W - CRC_W);

    if (LFSR_SEED == 16'h0 || CRC_W < 2 || CRC_W > CRC_MAX_W || WIDTH < 1) begin : g_bad_param
        $error("tdr_scan_chain_crc: unsupported parameter set");
    end

    logic [FRAME_W-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CRC_W-1:0]   crc_q, crc_d;
    logic [WIDTH-1:0]   upd_data_q, upd_data_d;
    logic               upd_valid_q, upd_valid_d;
    logic               crc_ok_q, crc_ok_d;
    logic               crc_err_q, crc_err_d;

    scan_act_e          act;
    logic               din;
    logic [CRC_MAX_W-1:0] crc_al;
    logic [CRC_W-1:0]   crc_adv;
    logic               unused_crc_al;

    // Capture beats shift beats update; losing strobes are dropped for the cycle
    always_comb begin
        act = ACT_IDLE;
        if (capture_en) begin
            act = ACT_CAPTURE;
        end else if (shift_en) begin
            act = ACT_SHIFT;
        end else if (update_en) begin
            act = ACT_UPDATE;
        end
    end

`ifdef SCAN_DESCRAMBLE_EN
    logic ks;

    tdr_keystream_lfsr #(
        .SEED (LFSR_SEED)
    ) u_keystream (
        .tck     (tck),
        .reset_n (reset_n),
        .reseed  (act == ACT_CAPTURE),
        .advance (act == ACT_SHIFT),
        .ks      (ks)
    );

    assign din = TDI ^ ks;
`else
    assign din = TDI;
`endif

    always_comb begin
        crc_al  = crc_step(CRC_MAX_W'(crc_q) << (CRC_MAX_W - CRC_W), din, POLY_AL);
        crc_adv = crc_al[CRC_MAX_W-1 -: CRC_W];
    end

    assign unused_crc_al = ^crc_al;

    always_comb begin
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        crc_d       = crc_q;
        upd_data_d  = upd_data_q;
        upd_valid_d = 1'b0;
        crc_ok_d    = crc_ok_q;
        crc_err_d   = crc_err_q;
        unique case (act)
            ACT_CAPTURE: begin
                sr_d      = {capture_data, {CRC_W{1'b0}}};
                cnt_d     = '0;
                crc_d     = '0;
                crc_err_d = 1'b0;
            end
            ACT_SHIFT: begin
                sr_d = {sr_q[FRAME_W-2:0], din};
                if (cnt_q != CNT_FULL) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // Only payload bits feed the CRC; trailing bits are the received CRC
                if (cnt_q < CNT_PAYLOAD) begin
                    crc_d = crc_adv;
                end
            end
            ACT_UPDATE: begin
                if (cnt_q == CNT_FULL && crc_q == sr_q[CRC_W-1:0]) begin
                    upd_data_d  = sr_q[FRAME_W-1:CRC_W];
                    upd_valid_d = 1'b1;
                    crc_ok_d    = 1'b1;
                end else begin
                    crc_ok_d  = 1'b0;
                    crc_err_d = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge tck or negedge reset_n) begin
        if (!reset_n) begin
            sr_q        <= '0;
            cnt_q       <= '0;
            crc_q       <= '0;
            upd_data_q  <= '0;
            upd_valid_q <= 1'b0;
            crc_ok_q    <= 1'b0;
            crc_err_q   <= 1'b0;
        end else begin
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            crc_q       <= crc_d;
            upd_data_q  <= upd_data_d;
            upd_valid_q <= upd_valid_d;
            crc_ok_q    <= crc_ok_d;
            crc_err_q   <= crc_err_d;
        end
    end

    assign TDO          = sr_q[FRAME_W-1];
    assign update_data  = upd_data_q;
    assign update_valid = upd_valid_q;
    assign crc_ok       = crc_ok_q;
    assign crc_err      = crc_err_q;

endmodule

// File: tb/tb_tdr_scan_chain_crc.sv
// tb/tb_tdr_scan_chain_crc.sv - self-checking bench for tdr_scan_chain_crc (WIDTH=8, CRC_W=8)
module tb_tdr_scan_chain_crc;

    localparam logic [15:0] SEED = 16'hACE1;

    logic       tck = 1'b0;
    logic       reset_n;
    logic       TDI;
    logic       shift_en;
    logic       capture_en;
    logic       update_en;
    logic [7:0] capture_data;
    logic [7:0] update_data;
    logic       update_valid;
    logic       crc_ok;
    logic       crc_err;
    logic       TDO;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] ks_q = SEED;

    always #5 tck = ~tck;

    tdr_scan_chain_crc #(
        .WIDTH     (8),
        .CRC_W     (8),
        .CRC_POLY  (8'h07),
        .LFSR_SEED (SEED)
    ) dut (
        .tck          (tck),
        .reset_n      (reset_n),
        .TDI          (TDI),
        .shift_en     (shift_en),
        .capture_en   (capture_en),
        .update_en    (update_en),
        .capture_data (capture_data),
        .update_data  (update_data),
        .update_valid (update_valid),
        .crc_ok       (crc_ok),
        .crc_err      (crc_err),
        .TDO          (TDO)
    );

    typedef struct {
        string      name;
        logic [7:0] pay;
        logic [7:0] crc;
        int         nbits;
        logic       exp_ok;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge tck);
        #1;
    endtask

    task automatic shift_bit(input logic b, input bit raw);
        logic k;
        k = 1'b0;
`ifdef SCAN_DESCRAMBLE_EN
        if (!raw) k = ks_q[0];
        ks_q = {^(ks_q & 16'h002D), ks_q[15:1]};
`else
        if (raw) k = 1'b0;
`endif
        TDI      = b ^ k;
        shift_en = 1'b1;
        step();
        shift_en = 1'b0;
        TDI      = 1'b0;
    endtask

    task automatic shift_frame(input logic [7:0] pay, input logic [7:0] crc, input int nbits, input bit raw);
        logic [15:0] frame;
        frame = {pay, crc};
        for (int i = 0; i < nbits; i++) begin
            shift_bit((i < 16) ? frame[15-i] : 1'b0, raw);
        end
    endtask

    task automatic do_capture(input logic [7:0] d);
        capture_data = d;
        capture_en   = 1'b1;
        step();
        capture_en   = 1'b0;
        ks_q         = SEED;
    endtask

    task automatic do_update();
        update_en = 1'b1;
        step();
        update_en = 1'b0;
    endtask

    initial begin
        logic [15:0] tdo_exp;

        vecs[0] = '{"p01",        8'h01, 8'h07, 16, 1'b1, 8'h01};
        vecs[1] = '{"pFF",        8'hFF, 8'hF3, 16, 1'b1, 8'hFF};
        vecs[2] = '{"pFF_badcrc", 8'hFF, 8'hF2, 16, 1'b0, 8'hFF};
        vecs[3] = '{"short15",    8'h01, 8'h07, 15, 1'b0, 8'hFF};
        vecs[4] = '{"pA5",        8'hA5, 8'h72, 16, 1'b1, 8'hA5};
        vecs[5] = '{"long17",     8'hA5, 8'h72, 17, 1'b0, 8'hA5};
        vecs[6] = '{"p00",        8'h00, 8'h00, 16, 1'b1, 8'h00};

        reset_n      = 1'b0;
        TDI          = 1'b0;
        shift_en     = 1'b0;
        capture_en   = 1'b0;
        update_en    = 1'b0;
        capture_data = 8'h00;
        step();
        step();
        chk("rst_data",  update_data,  8'h00);
        chk("rst_valid", update_valid, 1'b0);
        chk("rst_ok",    crc_ok,       1'b0);
        chk("rst_err",   crc_err,      1'b0);
        chk("rst_tdo",   TDO,          1'b0);
        reset_n = 1'b1;
        ks_q    = SEED;
        step();

        // Plain frame straight after reset, no capture
        shift_frame(8'h01, 8'h07, 16, 1'b0);
        do_update();
        chk("first_data",  update_data,  8'h01);
        chk("first_ok",    crc_ok,       1'b1);
        chk("first_err",   crc_err,      1'b0);
        chk("first_valid", update_valid, 1'b1);
        step();
        chk("first_valid_end", update_valid, 1'b0);

        for (int v = 0; v < 7; v++) begin
            do_capture(8'h3C);
            shift_frame(vecs[v].pay, vecs[v].crc, vecs[v].nbits, 1'b0);
            do_update();
            chk({vecs[v].name, "_data"},  update_data,  vecs[v].exp_data);
            chk({vecs[v].name, "_ok"},    crc_ok,       vecs[v].exp_ok);
            chk({vecs[v].name, "_err"},   crc_err,      !vecs[v].exp_ok);
            chk({vecs[v].name, "_valid"}, update_valid, vecs[v].exp_ok);
            step();
            chk({vecs[v].name, "_valid_end"}, update_valid, 1'b0);
        end

        // Repeated update with no new shifts passes again
        do_capture(8'h00);
        shift_frame(8'h01, 8'h07, 16, 1'b0);
        do_update();
        chk("b2b1_valid", update_valid, 1'b1);
        step();
        chk("b2b_gap_valid", update_valid, 1'b0);
        do_update();
        chk("b2b2_data",  update_data,  8'h01);
        chk("b2b2_ok",    crc_ok,       1'b1);
        chk("b2b2_valid", update_valid, 1'b1);
        step();
        chk("b2b2_valid_end", update_valid, 1'b0);

        // Short frame sets crc_err; capture clears it and reloads TDO stream
        do_capture(8'h00);
        shift_frame(8'h01, 8'h07, 15, 1'b0);
        do_update();
        chk("short_err",  crc_err,     1'b1);
        chk("short_ok",   crc_ok,      1'b0);
        chk("short_data", update_data, 8'h01);
        do_capture(8'hA5);
        chk("cap_clr_err", crc_err, 1'b0);
        tdo_exp = 16'hA500;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("tdo_seq%0d", i), TDO, tdo_exp[15-i]);
            shift_bit(1'b0, 1'b1);
        end

        // Simultaneous strobes: only the capture takes effect
        do_capture(8'h00);
        shift_frame(8'hFF, 8'hF3, 16, 1'b0);
        capture_data = 8'hC3;
        capture_en   = 1'b1;
        shift_en     = 1'b1;
        update_en    = 1'b1;
        TDI          = 1'b0;
        step();
        capture_en   = 1'b0;
        shift_en     = 1'b0;
        update_en    = 1'b0;
        ks_q         = SEED;
        chk("simul_data",  update_data,  8'h01);
        chk("simul_valid", update_valid, 1'b0);
        chk("simul_tdo",   TDO,          1'b1);
        chk("simul_err",   crc_err,      1'b0);
        do_update();
        chk("simul_cnt0_ok",   crc_ok,      1'b0);
        chk("simul_cnt0_data", update_data, 8'h01);

        // Asynchronous reset mid-frame
        do_capture(8'h00);
        shift_frame(8'hFF, 8'hF3, 16, 1'b0);
        do_update();
        chk("pre_rst_data", update_data, 8'hFF);
        do_capture(8'h04);
        shift_frame(8'h01, 8'h07, 5, 1'b0);
        chk("pre_rst_tdo", TDO, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_data",  update_data,  8'h00);
        chk("async_rst_ok",    crc_ok,       1'b0);
        chk("async_rst_err",   crc_err,      1'b0);
        chk("async_rst_valid", update_valid, 1'b0);
        chk("async_rst_tdo",   TDO,          1'b0);
        reset_n = 1'b1;
        ks_q    = SEED;
        shift_frame(8'h01, 8'h07, 16, 1'b0);
        do_update();
        chk("post_rst_data", update_data, 8'h01);
        chk("post_rst_ok",   crc_ok,      1'b1);

`ifdef SCAN_DESCRAMBLE_EN
        do_capture(8'h00);
        shift_frame(8'hFF, 8'hF3, 16, 1'b0);
        do_update();
        chk("ds_pre_data", update_data, 8'hFF);
        do_capture(8'h00);
        shift_frame(8'h01, 8'h07, 16, 1'b1);
        do_update();
        chk("ds_raw_ok",   crc_ok,      1'b0);
        chk("ds_raw_err",  crc_err,     1'b1);
        chk("ds_raw_data", update_data, 8'hFF);
        do_capture(8'h00);
        shift_frame(8'h01, 8'h07, 16, 1'b0);
        do_update();
        chk("ds_scr_data", update_data, 8'h01);
        chk("ds_scr_ok",   crc_ok,      1'b1);
`endif

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
